// File: rtl/multi_strip_pkg.sv
// Shared definitions for the multi-strip xx6812 driver: FSM encoding,
// per-LED bit count, 12 MHz default timing and small helper functions.
package multi_strip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  localparam int BITS_PER_LED       = 24;
  localparam int BIT_W              = $clog2(BITS_PER_LED);
  localparam int DEF_BIT_CYCLES     = 15;
  localparam int DEF_T0H_CYCLES     = 4;
  localparam int DEF_T1H_CYCLES     = 9;
  localparam int DEF_LATCH_CYCLES   = 960;

  // Counter width for a limit, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  // Per-byte brightness scale: (c * (b + 1)) >> 8, so b = 255 is identity.
  function automatic logic [23:0] scale_grb(input logic [23:0] c, input logic [7:0] b);
    logic [15:0] p;
    logic [23:0] r;
    r = 24'h000000;
    for (int i = 0; i < 3; i++) begin
      p = {8'h00, c[8*i +: 8]} * ({8'h00, b} + 16'h0001);
      r[8*i +: 8] = p[15:8];
    end
    return r;
  endfunction

endpackage

// File: rtl/strip_bit_shifter.sv
// One strip lane: 24-bit shift register, prefetch buffer and registered
// pulse-width encoder. Optional scaling under MULTI_STRIP_DRIVER_BRIGHTNESS_EN.
module strip_bit_shifter
  import multi_strip_pkg::*;
#(
  parameter int CW         = 4,
  parameter int T0H_CYCLES = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES = DEF_T1H_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load_first_i,
  input  logic                    capture_i,
  input  logic                    load_next_i,
  input  logic                    shift_i,
  input  logic                    active_i,
  input  logic [CW-1:0]           cycle_i,
  input  logic [BITS_PER_LED-1:0] data_i,
`ifdef MULTI_STRIP_DRIVER_BRIGHTNESS_EN
  input  logic [7:0]              brightness_i,
`endif
  output logic                    strip_o
);

  localparam logic [CW-1:0] T0H_C = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H_C = CW'(T1H_CYCLES);

  logic [BITS_PER_LED-1:0] shift_q, shift_d;
  logic [BITS_PER_LED-1:0] buf_q, buf_d;
  logic [BITS_PER_LED-1:0] word_s;
  logic                    strip_q, strip_d;

`ifdef MULTI_STRIP_DRIVER_BRIGHTNESS_EN
  assign word_s = scale_grb(data_i, brightness_i);
`else
  assign word_s = data_i;
`endif

  // Next-state for shift register, prefetch buffer and encoded output bit.
  always_comb begin
    shift_d = shift_q;
    buf_d   = buf_q;
    strip_d = 1'b0;
    if (load_first_i) begin
      shift_d = word_s;
    end else if (load_next_i) begin
      shift_d = buf_q;
    end else if (shift_i) begin
      shift_d = {shift_q[BITS_PER_LED-2:0], 1'b0};
    end else begin
      shift_d = shift_q;
    end
    if (capture_i) begin
      buf_d = word_s;
    end else begin
      buf_d = buf_q;
    end
    if (active_i) begin
      strip_d = (cycle_i < (shift_q[BITS_PER_LED-1] ? T1H_C : T0H_C));
    end else begin
      strip_d = 1'b0;
    end
  end

  // Lane state registers; reset drops the strip output immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= {BITS_PER_LED{1'b0}};
      buf_q   <= {BITS_PER_LED{1'b0}};
      strip_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      buf_q   <= buf_d;
      strip_q <= strip_d;
    end
  end

  assign strip_o = strip_q;

endmodule

// File: rtl/multi_strip_driver.sv
// Drives NUM_STRIPS xx6812 strips in parallel from frame memory: frame FSM,
// shared bit/cycle counters and read port. Optional MULTI_STRIP_DRIVER_BRIGHTNESS_EN.
module multi_strip_driver
  import multi_strip_pkg::*;
#(
  parameter int NUM_STRIPS     = 4,
  parameter int LEDS_PER_STRIP = 144,
  parameter int ADDR_W         = 8,
  parameter int BIT_CYCLES     = DEF_BIT_CYCLES,
  parameter int T0H_CYCLES     = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES     = DEF_T1H_CYCLES,
  parameter int LATCH_CYCLES   = DEF_LATCH_CYCLES
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               frame_start,
`ifdef MULTI_STRIP_DRIVER_BRIGHTNESS_EN
  input  logic [7:0]                         brightness,
`endif
  output logic                               read_enable,
  output logic [ADDR_W-1:0]                  read_address,
  input  logic [BITS_PER_LED*NUM_STRIPS-1:0] read_data,
  output logic [NUM_STRIPS-1:0]              strip,
  output logic                               busy,
  output logic                               frame_done
);

  localparam int CW  = clog2_min1(BIT_CYCLES);
  localparam int LW  = clog2_min1(LEDS_PER_STRIP);
  localparam int LTW = clog2_min1(LATCH_CYCLES);

  localparam logic [CW-1:0]    CYC_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0]    CYC_ONE    = CW'(1'b1);
  localparam logic [LW-1:0]    LED_LAST   = LW'(LEDS_PER_STRIP - 1);
  localparam logic [LTW-1:0]   LATCH_LAST = LTW'(LATCH_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_TOP    = BIT_W'(BITS_PER_LED - 1);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1'b1);
  localparam logic [BIT_W-1:0] BIT_ZERO   = {BIT_W{1'b0}};

  state_e             state_q, state_d;
  logic               fetch_wait_q, fetch_wait_d;
  logic [CW-1:0]      cycle_q, cycle_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [LW-1:0]      led_q, led_d;
  logic [LTW-1:0]     latch_q, latch_d;
  logic               rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load_first_s, capture_s, load_next_s, shift_s, active_s;
`ifdef MULTI_STRIP_DRIVER_BRIGHTNESS_EN
  logic [7:0]         bright_q, bright_d;
`endif

  // Frame sequencing, shared counters and memory-read strobes.
  always_comb begin
    state_d      = state_q;
    fetch_wait_d = fetch_wait_q;
    cycle_d      = cycle_q;
    bit_d        = bit_q;
    led_d        = led_q;
    latch_d      = latch_q;
    rd_en_d      = 1'b0;
    addr_d       = addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    load_first_s = 1'b0;
    capture_s    = 1'b0;
    load_next_s  = 1'b0;
    shift_s      = 1'b0;
`ifdef MULTI_STRIP_DRIVER_BRIGHTNESS_EN
    bright_d     = bright_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse is dropped on purpose.
        if (frame_start && !done_q) begin
          state_d      = ST_FETCH;
          fetch_wait_d = 1'b0;
          rd_en_d      = 1'b1;
          addr_d       = {ADDR_W{1'b0}};
          busy_d       = 1'b1;
`ifdef MULTI_STRIP_DRIVER_BRIGHTNESS_EN
          bright_d     = brightness;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (!fetch_wait_q) begin
          fetch_wait_d = 1'b1;
        end else begin
          load_first_s = 1'b1;
          fetch_wait_d = 1'b0;
          state_d      = ST_SHIFT;
          cycle_d      = {CW{1'b0}};
          bit_d        = BIT_TOP;
          led_d        = {LW{1'b0}};
        end
      end
      ST_SHIFT: begin
        capture_s = (cycle_q == CYC_ONE) && (bit_q == BIT_ZERO) && (led_q != LED_LAST);
        if (cycle_q == CYC_LAST) begin
          cycle_d = {CW{1'b0}};
          if (bit_q == BIT_ZERO) begin
            bit_d = BIT_TOP;
            if (led_q == LED_LAST) begin
              state_d = ST_LATCH;
              latch_d = {LTW{1'b0}};
            end else begin
              led_d       = led_q + LW'(1'b1);
              load_next_s = 1'b1;
            end
          end else begin
            bit_d   = bit_q - BIT_ONE;
            shift_s = 1'b1;
            // Prefetch so the read lands on cycle 0 of the last bit.
            if ((bit_q == BIT_ONE) && (led_q != LED_LAST)) begin
              rd_en_d = 1'b1;
              addr_d  = ADDR_W'(led_q) + ADDR_W'(1'b1);
            end else begin
              rd_en_d = 1'b0;
            end
          end
        end else begin
          cycle_d = cycle_q + CW'(1'b1);
        end
      end
      ST_LATCH: begin
        if (latch_q == LATCH_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          latch_d = latch_q + LTW'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign active_s = (state_q == ST_SHIFT);

  // Control and interface registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      fetch_wait_q <= 1'b0;
      cycle_q      <= {CW{1'b0}};
      bit_q        <= BIT_ZERO;
      led_q        <= {LW{1'b0}};
      latch_q      <= {LTW{1'b0}};
      rd_en_q      <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef MULTI_STRIP_DRIVER_BRIGHTNESS_EN
      bright_q     <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      fetch_wait_q <= fetch_wait_d;
      cycle_q      <= cycle_d;
      bit_q        <= bit_d;
      led_q        <= led_d;
      latch_q      <= latch_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef MULTI_STRIP_DRIVER_BRIGHTNESS_EN
      bright_q     <= bright_d;
`endif
    end
  end

  assign read_enable  = rd_en_q;
  assign read_address = addr_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;

  for (genvar k = 0; k < NUM_STRIPS; k++) begin : g_strip
    strip_bit_shifter #(
      .CW         (CW),
      .T0H_CYCLES (T0H_CYCLES),
      .T1H_CYCLES (T1H_CYCLES)
    ) u_shifter (
      .clock        (clock),
      .reset_n      (reset_n),
      .load_first_i (load_first_s),
      .capture_i    (capture_s),
      .load_next_i  (load_next_s),
      .shift_i      (shift_s),
      .active_i     (active_s),
      .cycle_i      (cycle_q),
      .data_i       (read_data[BITS_PER_LED*k +: BITS_PER_LED]),
`ifdef MULTI_STRIP_DRIVER_BRIGHTNESS_EN
      .brightness_i (bright_q),
`endif
      .strip_o      (strip[k])
    );
  end

endmodule

// File: tb/tb_multi_strip_driver.sv
// Scoreboard bench for multi_strip_driver: stimulus pushes expected reads,
// decoded words and frame timing; negedge monitors pop and compare.
module tb_multi_strip_driver;

  localparam int NS  = 2;
  localparam int L   = 3;
  localparam int AW  = 8;
  localparam int BC  = 15;
  localparam int T0H = 4;
  localparam int T1H = 9;
  localparam int LAT = 960;
  localparam int FRAME_CYC = 2 + L * 24 * BC + LAT;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              read_enable;
  logic [AW-1:0]     read_address;
  logic [24*NS-1:0]  read_data = '0;
  logic [NS-1:0]     strip;
  logic              busy;
  logic              frame_done;
`ifdef MULTI_STRIP_DRIVER_BRIGHTNESS_EN
  logic [7:0]        brightness = 8'hFF;
`endif

  logic [24*NS-1:0]  mem [256];
  int                cyc = 0;
  int                n_vec = 0;
  int                n_miss = 0;

  logic [AW-1:0]     exp_addr[$];
  logic [23:0]       exp_w0[$];
  logic [23:0]       exp_w1[$];
  int                exp_done[$];
  int                exp_rise[$];

  multi_strip_driver #(
    .NUM_STRIPS     (NS),
    .LEDS_PER_STRIP (L),
    .ADDR_W         (AW),
    .BIT_CYCLES     (BC),
    .T0H_CYCLES     (T0H),
    .T1H_CYCLES     (T1H),
    .LATCH_CYCLES   (LAT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
`ifdef MULTI_STRIP_DRIVER_BRIGHTNESS_EN
    .brightness   (brightness),
`endif
    .read_enable  (read_enable),
    .read_address (read_address),
    .read_data    (read_data),
    .strip        (strip),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Synchronous frame memory: data valid the cycle after read_enable.
  always @(posedge clock) if (read_enable) read_data <= mem[read_address];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [23:0] exp_of(input logic [23:0] w);
`ifdef MULTI_STRIP_DRIVER_BRIGHTNESS_EN
    logic [23:0] r;
    for (int i = 0; i < 3; i++) r[8*i +: 8] = 8'((int'(w[8*i +: 8]) * (int'(brightness) + 1)) / 256);
    return r;
`else
    return w;
`endif
  endfunction

  // Read-port monitor.
  always @(negedge clock) begin
    if (reset_n && read_enable) begin
      if (exp_addr.size() == 0) fail("read_unexpected");
      else check("read_address", 64'(read_address), 64'(exp_addr.pop_front()));
    end
  end

  // Strip decoder plus frame_done monitor.
  int          hi_cnt[NS];
  int          last_rise[NS];
  int          nrise[NS];
  int          nbits[NS];
  logic [23:0] acc[NS];
  logic        prev[NS];
  always @(negedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < NS; k++) begin
        hi_cnt[k] = 0; nrise[k] = 0; nbits[k] = 0; acc[k] = 24'h0; prev[k] = 1'b0; last_rise[k] = 0;
      end
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (strip[k] && !prev[k]) begin
          if (nrise[k] == 0) begin
            if (k == 0) begin
              if (exp_rise.size() == 0) fail("rise_unexpected");
              else check("first_rise_cycle", 64'(cyc), 64'(exp_rise.pop_front()));
            end
          end else begin
            check("bit_period", 64'(cyc - last_rise[k]), 64'(BC));
          end
          nrise[k]++;
          last_rise[k] = cyc;
          hi_cnt[k] = 1;
        end else if (strip[k]) begin
          hi_cnt[k]++;
        end else if (prev[k]) begin
          logic b;
          n_vec++;
          if (hi_cnt[k] == T1H) b = 1'b1;
          else if (hi_cnt[k] == T0H) b = 1'b0;
          else begin
            b = 1'b0;
            n_miss++;
            $display("FAIL high_time strip%0d: got %0d cycles, expected %0d or %0d", k, hi_cnt[k], T0H, T1H);
          end
          acc[k] = {acc[k][22:0], b};
          nbits[k]++;
          if (nbits[k] == 24) begin
            nbits[k] = 0;
            if (k == 0) begin
              if (exp_w0.size() == 0) fail("word_unexpected_s0");
              else check("word_strip0", 64'(acc[k]), 64'(exp_w0.pop_front()));
            end else begin
              if (exp_w1.size() == 0) fail("word_unexpected_s1");
              else check("word_strip1", 64'(acc[k]), 64'(exp_w1.pop_front()));
            end
          end
        end
        prev[k] = strip[k];
      end
      if (frame_done) begin
        if (exp_done.size() == 0) fail("done_unexpected");
        else check("frame_done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
        check("busy_low_at_done", 64'(busy), 64'd0);
        for (int k = 0; k < NS; k++) nrise[k] = 0;
      end
    end
  end

  // Expected response of a frame accepted at the next rising edge.
  task automatic push_frame();
    int c;
    c = cyc;
    for (int i = 0; i < L; i++) begin
      exp_addr.push_back(AW'(i));
      exp_w0.push_back(exp_of(mem[i][23:0]));
      exp_w1.push_back(exp_of(mem[i][47:24]));
    end
    exp_done.push_back(c + 1 + FRAME_CYC);
    exp_rise.push_back(c + 4);
  endtask

  task automatic pulse_frame();
    @(negedge clock);
    frame_start = 1'b1;
    push_frame();
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!frame_done && n < FRAME_CYC + 100) begin
      @(negedge clock);
      n++;
    end
    if (!frame_done) fail("frame_done_timeout");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = {24'h000001, 24'hFF0000};
    mem[1] = {24'h5A3C96, 24'hA5C30F};
    mem[2] = {24'hFFFFFF, 24'h800001};

    repeat (3) @(negedge clock);
    check("reset_strip", 64'(strip), 64'd0);
    check("reset_read_enable", 64'(read_enable), 64'd0);
    check("reset_read_address", 64'(read_address), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Frame 1, with a start pulse mid-frame that must be ignored.
    pulse_frame();
    repeat (100) @(negedge clock);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    check("busy_during_frame", 64'(busy), 64'd1);
    wait_done();

    // Start coincident with frame_done is dropped; the next cycle's is taken.
    for (int i = 0; i < L; i++) mem[i] = {24'(i), 24'(i)};
    frame_start = 1'b1;
    @(negedge clock);
    check("busy_after_coincident_start", 64'(busy), 64'd0);
    push_frame();
    @(negedge clock);
    frame_start = 1'b0;
    check("busy_after_accepted_start", 64'(busy), 64'd1);
    wait_done();

    // Frame 3 aborted by reset mid-frame.
    mem[0] = {24'h123456, 24'h654321};
    mem[1] = {24'hABCDEF, 24'hFEDCBA};
    mem[2] = {24'h0F1E2D, 24'h3C4B5A};
    repeat (2) @(negedge clock);
    pulse_frame();
    repeat (500) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midframe_reset_strip", 64'(strip), 64'd0);
    check("midframe_reset_busy", 64'(busy), 64'd0);
    check("midframe_reset_read_enable", 64'(read_enable), 64'd0);
    exp_addr.delete();
    exp_w0.delete();
    exp_w1.delete();
    exp_done.delete();
    exp_rise.delete();
    repeat (3) @(negedge clock);

    // Frame 4 after release restarts from address 0.
    mem[0] = {24'h00FF00, 24'hFF8001};
    mem[1] = {24'h0F0F0F, 24'hF0F0F0};
    mem[2] = {24'hC0FFEE, 24'h13579B};
`ifdef MULTI_STRIP_DRIVER_BRIGHTNESS_EN
    brightness = 8'h7F;
    check("scale_reference", 64'(exp_of(24'hFF8001)), 64'h7F4000);
`endif
    #2 reset_n = 1'b1;
    @(negedge clock);
    check("busy_after_reset_release", 64'(busy), 64'd0);
    pulse_frame();
    wait_done();
    repeat (5) @(negedge clock);

    check("pending_reads", 64'(exp_addr.size()), 64'd0);
    check("pending_words_s0", 64'(exp_w0.size()), 64'd0);
    check("pending_words_s1", 64'(exp_w1.size()), 64'd0);
    check("pending_done", 64'(exp_done.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
